// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: two-flop synchroniser, per-channel stability counter, registered edge pulses.
// Optional auto-repeat of rise pulses on held inputs when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_multi #(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYCLES = 65536,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] db_state,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_event
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (NUM_CH < 1 || STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("debounce_multi: illegal parameter set");
    end

    logic [NUM_CH-1:0] sync0_r;
    logic [NUM_CH-1:0] sync1_r;
    logic [NUM_CH-1:0] db_r;
    logic [NUM_CH-1:0] rise_r;
    logic [NUM_CH-1:0] fall_r;
    logic              any_r;
    logic [CNT_W-1:0]  cnt_r      [NUM_CH];
    logic [CNT_W-1:0]  cnt_next_s [NUM_CH];
    logic [NUM_CH-1:0] toggle_s;
    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] fall_s;
    logic [NUM_CH-1:0] rep_s;

    // Stability window: any cycle of agreement restarts the count; terminal count flips the state.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next_s[i] = '0;
            toggle_s[i]   = 1'b0;
            if (sync1_r[i] == db_r[i]) begin
                cnt_next_s[i] = '0;
            end else if (cnt_r[i] == CNT_LAST) begin
                toggle_s[i]   = 1'b1;
                cnt_next_s[i] = '0;
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
        rise_s = toggle_s & ~db_r;
        fall_s = toggle_s & db_r;
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold_r      [NUM_CH];
    logic [HOLD_W-1:0] hold_next_s [NUM_CH];
    logic [NUM_CH-1:0] phase_r;
    logic [NUM_CH-1:0] phase_next_s;

    // Hold timer: phase 0 waits the initial delay, phase 1 spaces the periodic repeats.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hold_next_s[i]  = hold_r[i];
            phase_next_s[i] = phase_r[i];
            rep_s[i]        = 1'b0;
            if (!db_r[i] || toggle_s[i]) begin
                hold_next_s[i]  = '0;
                phase_next_s[i] = 1'b0;
            end else if (!phase_r[i] && (hold_r[i] == DELAY_LAST)) begin
                rep_s[i]        = 1'b1;
                hold_next_s[i]  = '0;
                phase_next_s[i] = 1'b1;
            end else if (phase_r[i] && (hold_r[i] == PERIOD_LAST)) begin
                rep_s[i]        = 1'b1;
                hold_next_s[i]  = '0;
            end else begin
                hold_next_s[i]  = hold_r[i] + HOLD_W'(1);
            end
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_r[i] <= '0;
            end
        end else begin
            phase_r <= phase_next_s;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_r[i] <= hold_next_s[i];
            end
        end
    end
`else
    assign rep_s = '0;
`endif

    // Synchroniser, debounced state, counters and registered event outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_r <= '0;
            sync1_r <= '0;
            db_r    <= '0;
            rise_r  <= '0;
            fall_r  <= '0;
            any_r   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync0_r <= raw_in;
            sync1_r <= sync0_r;
            db_r    <= db_r ^ toggle_s;
            rise_r  <= rise_s | rep_s;
            fall_r  <= fall_s;
            any_r   <= |(rise_s | rep_s | fall_s);
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    assign db_state   = db_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign any_event  = any_r;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (NUM_CH=4, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Expected events are queued by the stimulus and consumed by a monitor whenever the DUT shows an event.
module tb_debounce_multi;

    logic       clk;
    logic       reset_n;
    logic [3:0] raw_in;
    logic [3:0] db_state;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       any_event;

    int edge_cnt = 0;
    int total    = 0;
    int bad      = 0;

    typedef struct {
        int         e;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] d;
    } ev_t;

    ev_t exp_q[$];

    debounce_multi #(
        .NUM_CH        (4),
        .STABLE_CYCLES (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .db_state   (db_state),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_event  (any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp_v, edge_cnt);
        end
    endtask

    task automatic push(input int e, input logic [3:0] r, input logic [3:0] f, input logic [3:0] d);
        ev_t ev;
        ev.e = e;
        ev.r = r;
        ev.f = f;
        ev.d = d;
        exp_q.push_back(ev);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every visible event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset_n && (any_event || (rise_pulse != 4'd0) || (fall_pulse != 4'd0))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({any_event, rise_pulse, fall_pulse}), 32'd0);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                check("ev_edge", 32'(edge_cnt), 32'(ev.e));
                check("ev_rise", 32'(rise_pulse), 32'(ev.r));
                check("ev_fall", 32'(fall_pulse), 32'(ev.f));
                check("ev_db",   32'(db_state), 32'(ev.d));
                check("ev_any",  32'(any_event), 32'd1);
            end
        end
    end

    initial begin
        int n;
        int t;
        raw_in  = 4'd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_db",   32'(db_state), 32'd0);
        check("reset_rise", 32'(rise_pulse), 32'd0);
        check("reset_fall", 32'(fall_pulse), 32'd0);
        check("reset_any",  32'(any_event), 32'd0);
        reset_n = 1'b1;
        step(2);

        // Clean press then release on channel 0.
        n = edge_cnt;
        raw_in[0] = 1'b1;
        push(n + 6, 4'b0001, 4'b0000, 4'b0001);
        step(5);
        check("press_db_early", 32'(db_state), 32'h0);
        step(1);
        check("press_db", 32'(db_state), 32'h1);
        step(2);
        n = edge_cnt;
        raw_in[0] = 1'b0;
        push(n + 6, 4'b0000, 4'b0001, 4'b0000);
        step(5);
        check("release_db_early", 32'(db_state), 32'h1);
        step(1);
        check("release_db", 32'(db_state), 32'h0);
        step(2);

        // Glitchy input on channel 1 never survives the window.
        raw_in[1] = 1'b1;
        step(3);
        raw_in[1] = 1'b0;
        step(1);
        raw_in[1] = 1'b1;
        step(3);
        raw_in[1] = 1'b0;
        step(8);
        check("glitch_db", 32'(db_state), 32'h0);

        // A pulse of exactly STABLE_CYCLES is accepted: rise then fall.
        n = edge_cnt;
        raw_in[1] = 1'b1;
        push(n + 6,  4'b0010, 4'b0000, 4'b0010);
        push(n + 10, 4'b0000, 4'b0010, 4'b0000);
        step(4);
        raw_in[1] = 1'b0;
        step(8);

        // Simultaneous rise on channels 2 and 3.
        n = edge_cnt;
        raw_in[3:2] = 2'b11;
        push(n + 6, 4'b1100, 4'b0000, 4'b1100);
        step(6);
        check("simul_db", 32'(db_state), 32'hc);
        step(1);
        check("simul_any_one_cycle", 32'(any_event), 32'd0);
        step(1);
        n = edge_cnt;
        raw_in[3:2] = 2'b00;
        push(n + 6, 4'b0000, 4'b1100, 4'b0000);
        step(8);

        // Reset in the middle of a stability window.
        raw_in[0] = 1'b1;
        step(2);
        reset_n = 1'b0;
        #1;
        check("midreset_db",   32'(db_state), 32'd0);
        check("midreset_rise", 32'(rise_pulse), 32'd0);
        check("midreset_any",  32'(any_event), 32'd0);
        step(2);
        check("midreset_hold_db", 32'(db_state), 32'd0);
        n = edge_cnt;
        reset_n = 1'b1;
        t = n + 6;
        push(t, 4'b0001, 4'b0000, 4'b0001);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        for (int k = 10; k <= 28; k += 3) begin
            push(t + k, 4'b0001, 4'b0000, 4'b0001);
        end
`endif
        // Release so the fall lands on the edge a repeat would otherwise use.
        step(31);
        raw_in[0] = 1'b0;
        push(t + 31, 4'b0000, 4'b0001, 4'b0000);
        step(10);
        check("final_db", 32'(db_state), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
